// File: rtl/icache_direct.sv
// -----------------------------------------------------------------------------
// icache_direct
//
// Direct-mapped, read-only instruction cache between the fetch stage and the
// instruction memory. Addresses are word addresses. A hit returns the word in
// the same cycle. A miss refills the whole line from memory one word at a time.
// It uses the same read/valid handshake that the fetch stage uses toward the
// cache.
//
// Address split: { TAG | IDX (log2 LINES) | OFF (log2 WORDS_PER_LINE) }
//
// Parameters
//   BITSIZE         address width in bits
//   LINES           number of lines (power of 2, >= 2)
//   WORDS_PER_LINE  32-bit words per line (power of 2, >= 2)
//
// Ports
//   clk          rising-edge clock
//   resetn_i     asynchronous active-low reset
//   IF_addr_i    fetch word address, held while IF_read_i=1 until IF_valid_o
//   IF_read_i    fetch read request
//   IF_data_o    instruction word, meaningful only when IF_valid_o=1
//   IF_valid_o   IF_data_o is valid for IF_addr_i this cycle
//   MEM_addr_o   refill word address
//   MEM_read_o   refill read request, address held until MEM_valid_i
//   MEM_data_i   refill read data
//   MEM_valid_i  refill data valid, one word per cycle
//   flush_i      invalidate all lines
//   hit_cnt_o    hit counter (ICACHE_STATS_EN only, else 0)
//   miss_cnt_o   miss counter (ICACHE_STATS_EN only, else 0)
//
// Optional feature macro: ICACHE_STATS_EN
//   When defined, the design has saturating 32-bit hit and miss counters.
//   When undefined, both counter outputs are tied to zero.
// -----------------------------------------------------------------------------
module icache_direct #(
   parameter int BITSIZE        = 32,
   parameter int LINES          = 16,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic               clk,
   input  logic               resetn_i,
   input  logic [BITSIZE-1:0] IF_addr_i,
   input  logic               IF_read_i,
   output logic [31:0]        IF_data_o,
   output logic               IF_valid_o,
   output logic [BITSIZE-1:0] MEM_addr_o,
   output logic               MEM_read_o,
   input  logic [31:0]        MEM_data_i,
   input  logic               MEM_valid_i,
   input  logic               flush_i,
   output logic [31:0]        hit_cnt_o,
   output logic [31:0]        miss_cnt_o
);

   localparam int OFF_W  = $clog2(WORDS_PER_LINE);
   localparam int IDX_W  = $clog2(LINES);
   localparam int TAG_W  = BITSIZE - OFF_W - IDX_W;
   localparam int LINE_W = BITSIZE - OFF_W;
   localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

   // Geometry checks
   if ((LINES < 2) || ((LINES & (LINES - 1)) != 0)) begin : g_bad_lines
      $fatal(1, "icache_direct: LINES must be a power of 2 and at least 2");
   end
   if ((WORDS_PER_LINE < 2) || ((WORDS_PER_LINE & (WORDS_PER_LINE - 1)) != 0)) begin : g_bad_words
      $fatal(1, "icache_direct: WORDS_PER_LINE must be a power of 2 and at least 2");
   end
   if (TAG_W < 1) begin : g_bad_tag
      $fatal(1, "icache_direct: BITSIZE too small for the chosen geometry");
   end

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_REFILL = 1'b1
   } state_t;

   // Control state
   state_t             state_q, state_d;
   logic [LINES-1:0]   valid_q, valid_d;
   logic [LINE_W-1:0]  line_q, line_d;        // {TAG, IDX} of the line being refilled
   logic [OFF_W-1:0]   cnt_q, cnt_d;          // refill word counter
   logic               flush_pend_q, flush_pend_d;

   // Storage. There is no reset here because the valid bits qualify every entry.
   logic [TAG_W-1:0]   tag_mem  [LINES];
   logic [31:0]        data_mem [LINES*WORDS_PER_LINE];

   logic [TAG_W-1:0]   req_tag;
   logic [IDX_W-1:0]   req_idx;
   logic [OFF_W-1:0]   req_off;
   logic [IDX_W-1:0]   fill_idx;
   logic [TAG_W-1:0]   fill_tag;
   logic               lookup_hit;
   logic               data_we;
   logic               tag_we;

   assign req_tag  = IF_addr_i[BITSIZE-1 -: TAG_W];
   assign req_idx  = IF_addr_i[OFF_W +: IDX_W];
   assign req_off  = IF_addr_i[OFF_W-1:0];
   assign fill_idx = line_q[IDX_W-1:0];
   assign fill_tag = line_q[LINE_W-1 -: TAG_W];

   // A flush in the same cycle suppresses a hit. The lookup then sees the
   // cleared valids on the next cycle.
   assign lookup_hit = (state_q == S_IDLE) && IF_read_i && !flush_i &&
                       valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

   assign IF_valid_o = lookup_hit;
   assign IF_data_o  = lookup_hit ? data_mem[{req_idx, req_off}] : 32'h0;

   // The line base is aligned, so concatenating the counter gives base+counter.
   // That address cannot carry into the index or tag bits.
   assign MEM_read_o = (state_q == S_REFILL);
   assign MEM_addr_o = MEM_read_o ? {line_q, cnt_q} : '0;

   assign data_we = MEM_read_o && MEM_valid_i;

   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      line_d       = line_q;
      cnt_d        = cnt_q;
      flush_pend_d = flush_pend_q;
      tag_we       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (flush_i) begin
               valid_d = '0;
            end else if (IF_read_i && !lookup_hit) begin
               // Drop the old line at once. A later flush or reset then
               // cannot leave a half-overwritten line marked valid.
               line_d           = IF_addr_i[BITSIZE-1:OFF_W];
               valid_d[req_idx] = 1'b0;
               cnt_d            = '0;
               flush_pend_d     = 1'b0;
               state_d          = S_REFILL;
            end
         end

         S_REFILL: begin
            if (MEM_valid_i) begin
               if (flush_pend_q || flush_i) begin
                  // The outstanding word has arrived. Abandon the line.
                  valid_d      = '0;
                  flush_pend_d = 1'b0;
                  cnt_d        = '0;
                  state_d      = S_IDLE;
               end else if (cnt_q == LAST_WORD) begin
                  valid_d[fill_idx] = 1'b1;
                  tag_we            = 1'b1;
                  cnt_d             = '0;
                  state_d           = S_IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else if (flush_i) begin
               flush_pend_d = 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q      <= S_IDLE;
         valid_q      <= '0;
         line_q       <= '0;
         cnt_q        <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         valid_q      <= valid_d;
         line_q       <= line_d;
         cnt_q        <= cnt_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   // Words of an abandoned refill may land in data_mem. They are harmless
   // because the line stays invalid.
   always_ff @(posedge clk) begin
      if (data_we) begin
         data_mem[{fill_idx, cnt_q}] <= MEM_data_i;
      end
      if (tag_we) begin
         tag_mem[fill_idx] <= fill_tag;
      end
   end

`ifdef ICACHE_STATS_EN
   logic [31:0] hit_cnt_q, hit_cnt_d;
   logic [31:0] miss_cnt_q, miss_cnt_d;
   logic        miss_evt;

   assign miss_evt = (state_q == S_IDLE) && (state_d == S_REFILL);

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (IF_valid_o && (hit_cnt_q != 32'hFFFF_FFFF)) begin
         hit_cnt_d = hit_cnt_q + 32'd1;
      end
      if (miss_evt && (miss_cnt_q != 32'hFFFF_FFFF)) begin
         miss_cnt_d = miss_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge resetn_i) begin
      if (!resetn_i) begin
         hit_cnt_q  <= 32'h0;
         miss_cnt_q <= 32'h0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_cnt_o  = hit_cnt_q;
   assign miss_cnt_o = miss_cnt_q;
`else
   assign hit_cnt_o  = 32'h0;
   assign miss_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// -----------------------------------------------------------------------------
// tb_icache_direct
//
// Directed bench for icache_direct with default parameters (16 lines of 4
// words). The memory model answers a read after a programmable number of wait
// cycles with data 0xC0DE0000 | addr[15:0]. It logs every accepted address.
// -----------------------------------------------------------------------------
module tb_icache_direct;

   logic        clk = 1'b0;
   logic        resetn_i;
   logic [31:0] IF_addr_i;
   logic        IF_read_i;
   logic [31:0] IF_data_o;
   logic        IF_valid_o;
   logic [31:0] MEM_addr_o;
   logic        MEM_read_o;
   logic [31:0] MEM_data_i;
   logic        MEM_valid_i;
   logic        flush_i;
   logic [31:0] hit_cnt_o;
   logic [31:0] miss_cnt_o;

   int          total = 0;
   int          bad   = 0;
   int          lat   = 0;
   int          wcnt  = 0;
   logic [31:0] mem_log [$];

   always #5 clk = ~clk;

   icache_direct #(
      .BITSIZE        (32),
      .LINES          (16),
      .WORDS_PER_LINE (4)
   ) dut (
      .clk         (clk),
      .resetn_i    (resetn_i),
      .IF_addr_i   (IF_addr_i),
      .IF_read_i   (IF_read_i),
      .IF_data_o   (IF_data_o),
      .IF_valid_o  (IF_valid_o),
      .MEM_addr_o  (MEM_addr_o),
      .MEM_read_o  (MEM_read_o),
      .MEM_data_i  (MEM_data_i),
      .MEM_valid_i (MEM_valid_i),
      .flush_i     (flush_i),
      .hit_cnt_o   (hit_cnt_o),
      .miss_cnt_o  (miss_cnt_o)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Memory responder, evaluated once per cycle just after the clock edge
   task automatic mem_step();
      if (MEM_read_o) begin
         if (wcnt >= lat) begin
            MEM_valid_i = 1'b1;
            MEM_data_i  = 32'hC0DE_0000 | {16'h0, MEM_addr_o[15:0]};
            mem_log.push_back(MEM_addr_o);
            wcnt = 0;
         end else begin
            MEM_valid_i = 1'b0;
            wcnt++;
         end
      end else begin
         MEM_valid_i = 1'b0;
         wcnt = 0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      mem_step();
      #1;
   endtask

   // Issue a read, wait for IF_valid_o, and check data and the number of
   // cycles spent before the hit cycle. The task then clocks the hit cycle.
   task automatic do_read(input string tag, input logic [31:0] addr,
                          input logic [31:0] exp, input int exp_lat);
      int n = 0;
      IF_addr_i = addr;
      IF_read_i = 1'b1;
      #1;
      while (!IF_valid_o && n < 60) begin
         step();
         n++;
      end
      check_val({tag, "_valid"}, {31'h0, IF_valid_o}, 32'h1);
      check_val({tag, "_data"}, IF_data_o, exp);
      check_val({tag, "_lat"}, n, exp_lat);
      step();
   endtask

   task automatic check_log(input string tag, input logic [31:0] base, input int n);
      check_val({tag, "_nreads"}, mem_log.size(), n);
      for (int i = 0; i < n && i < mem_log.size(); i++) begin
         check_val({tag, "_addr"}, mem_log[i], base + i);
      end
   endtask

   initial begin
      int guard;
      int waited;
      int bp_bad;

      resetn_i    = 1'b0;
      IF_addr_i   = 32'h0;
      IF_read_i   = 1'b1;
      MEM_data_i  = 32'h0;
      MEM_valid_i = 1'b0;
      flush_i     = 1'b0;

      // ---------------- reset state ----------------
      step();
      step();
      check_val("rst_if_valid", {31'h0, IF_valid_o}, 32'h0);
      check_val("rst_if_data", IF_data_o, 32'h0);
      check_val("rst_mem_read", {31'h0, MEM_read_o}, 32'h0);
      check_val("rst_mem_addr", MEM_addr_o, 32'h0);
      check_val("rst_hit_cnt", hit_cnt_o, 32'h0);
      check_val("rst_miss_cnt", miss_cnt_o, 32'h0);
      IF_read_i = 1'b0;
      resetn_i  = 1'b1;
      step();

      // ---------------- cold miss, memory 2 cycles late ----------------
      lat = 2;
      mem_log.delete();
      do_read("cold0", 32'h0, 32'hC0DE_0000, 13);
      check_log("cold", 32'h0, 4);
      for (int a = 1; a < 4; a++) begin
         IF_addr_i = a;
         #1;
         check_val("cold_hit_nomem", {31'h0, MEM_read_o}, 32'h0);
         do_read("cold_hit", a, 32'hC0DE_0000 | a, 0);
      end
      IF_read_i = 1'b0;
      step();
      check_val("cold_nomore_reads", mem_log.size(), 4);
`ifdef ICACHE_STATS_EN
      check_val("cold_hit_cnt", hit_cnt_o, 32'd4);
      check_val("cold_miss_cnt", miss_cnt_o, 32'd1);
`else
      check_val("cold_hit_cnt", hit_cnt_o, 32'd0);
      check_val("cold_miss_cnt", miss_cnt_o, 32'd0);
`endif

      // ---------------- conflict on index 0 ----------------
      lat = 0;
      mem_log.delete();
      do_read("conf40", 32'h40, 32'hC0DE_0040, 5);
      check_log("conf40", 32'h40, 4);
      mem_log.delete();
      do_read("conf00", 32'h0, 32'hC0DE_0000, 5);
      check_log("conf00", 32'h0, 4);

      // ---------------- flush in IDLE ----------------
      do_read("fli_fill", 32'h10, 32'hC0DE_0010, 5);
      flush_i = 1'b1;
      #1;
      check_val("fli_valid_in_flush", {31'h0, IF_valid_o}, 32'h0);
      step();
      flush_i = 1'b0;
      mem_log.delete();
      do_read("fli_refill", 32'h10, 32'hC0DE_0010, 5);
      check_log("fli_refill", 32'h10, 4);
      IF_read_i = 1'b0;
      step();

      // ---------------- flush mid-refill ----------------
      lat = 2;
      mem_log.delete();
      IF_addr_i = 32'h20;
      IF_read_i = 1'b1;
      guard = 0;
      step();
      while (!(MEM_addr_o == 32'h21 && !MEM_valid_i) && guard < 40) begin
         step();
         guard++;
      end
      check_val("flr_at_word1", MEM_addr_o, 32'h21);
      flush_i   = 1'b1;
      IF_read_i = 1'b0;
      step();
      flush_i = 1'b0;
      check_val("flr_await_read", {31'h0, MEM_read_o}, 32'h1);
      check_val("flr_await_addr", MEM_addr_o, 32'h21);
      guard = 0;
      while (MEM_read_o && guard < 20) begin
         step();
         guard++;
      end
      check_val("flr_ended", {31'h0, MEM_read_o}, 32'h0);
      check_log("flr_partial", 32'h20, 2);
      mem_log.delete();
      do_read("flr_retry", 32'h20, 32'hC0DE_0020, 13);
      check_log("flr_retry", 32'h20, 4);

      // ---------------- reset mid-refill ----------------
      mem_log.delete();
      IF_addr_i = 32'h0;
      IF_read_i = 1'b1;
      guard = 0;
      step();
      while (MEM_addr_o != 32'h2 && guard < 40) begin
         step();
         guard++;
      end
      check_val("rstm_at_word2", MEM_addr_o, 32'h2);
      resetn_i = 1'b0;
      #1;
      check_val("rstm_mem_read", {31'h0, MEM_read_o}, 32'h0);
      check_val("rstm_mem_addr", MEM_addr_o, 32'h0);
      check_val("rstm_hit_cnt", hit_cnt_o, 32'h0);
      check_val("rstm_miss_cnt", miss_cnt_o, 32'h0);
      IF_read_i = 1'b0;
      step();
      step();
      resetn_i = 1'b1;
      step();
      lat = 0;
      do_read("rstm_line20", 32'h20, 32'hC0DE_0020, 5);
      mem_log.delete();
      do_read("rstm_line00", 32'h0, 32'hC0DE_0000, 5);
      check_log("rstm_line00", 32'h0, 4);

      // ---------------- back-pressure on word 0 ----------------
      lat = 10;
      mem_log.delete();
      IF_addr_i = 32'h30;
      IF_read_i = 1'b1;
      step();
      IF_read_i = 1'b0;
      IF_addr_i = 32'h99;
      waited = 1;
      bp_bad = 0;
      while (mem_log.size() == 0 && waited < 40) begin
         if (!MEM_read_o || MEM_addr_o != 32'h30 || IF_valid_o) bp_bad++;
         step();
         waited++;
      end
      if (!MEM_read_o || MEM_addr_o != 32'h30) bp_bad++;
      check_val("bp_stable", bp_bad, 32'd0);
      check_val("bp_wait", waited, 32'd11);
      lat = 0;
      guard = 0;
      while (MEM_read_o && guard < 20) begin
         step();
         guard++;
      end
      check_val("bp_ended", {31'h0, MEM_read_o}, 32'h0);
      check_log("bp", 32'h30, 4);
      do_read("bp_hit", 32'h33, 32'hC0DE_0033, 0);
      IF_read_i = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the instruction fetch stage and instruction memory.
- Serves the fetch stage's word-addressed read requests:
  - hit: from local storage in the same cycle;
  - miss: refills a whole line from memory, one word at a time, using the fetch stage's own read/valid handshake.
- Provides a flush input for future branch/fence support.

Parameters:
- BITSIZE, 32, address width in bits; addresses are word addresses.
- LINES, 16, number of cache lines; power of 2, at least 2.
- WORDS_PER_LINE, 4, 32-bit words per line; power of 2, at least 2.

Ports:
- clk  input  1  clock, rising edge.
- resetn_i  input  1  reset, asynchronous, active-low.
- IF_addr_i  input  BITSIZE  word address requested by fetch; held stable while IF_read_i=1 until IF_valid_o.
- IF_read_i  input  1  fetch read request.
- IF_data_o  output  32  instruction word; meaningful only when IF_valid_o=1.
- IF_valid_o  output  1  IF_data_o valid for IF_addr_i this cycle.
- MEM_addr_o  output  BITSIZE  refill word address to memory.
- MEM_read_o  output  1  memory read request; held with a stable address until MEM_valid_i.
- MEM_data_i  input  32  memory read data.
- MEM_valid_i  input  1  memory data valid; one word accepted per cycle with valid=1.
- flush_i  input  1  invalidate all lines.
- hit_cnt_o  output  32  hit counter (see Optional Feature).
- miss_cnt_o  output  32  miss counter (see Optional Feature).

Behaviour:
- Address split:
  - OFF = log2(WORDS_PER_LINE) LSBs;
  - IDX = next log2(LINES) bits;
  - TAG = remaining upper bits.
- Storage: per line, one valid bit, one TAG, and WORDS_PER_LINE data words. Only valid bits need reset.
- Reset (async, resetn_i=0):
  - state=IDLE; all valid bits=0; refill counter=0; counters=0;
  - IF_valid_o=0, MEM_read_o=0, MEM_addr_o=0, IF_data_o=0.
  - Reset mid-refill abandons the refill immediately, with no line written.
- IDLE:
  - Hit (IF_read_i=1, valid[IDX]=1, tag match): combinational; IF_valid_o=1 and IF_data_o=data[IDX][OFF] in the same cycle (0-cycle latency).
  - IF_valid_o=0 whenever IF_read_i=0.
  - Miss with IF_read_i=1:
    - latch line base = {TAG,IDX,OFF=0};
    - clear valid[IDX] immediately;
    - next state REFILL, word counter=0.
- REFILL:
  - MEM_read_o=1; MEM_addr_o = base + counter.
  - On MEM_valid_i=1: write MEM_data_i into data[IDX][counter] and increment counter.
  - After the final word (counter = WORDS_PER_LINE-1 with valid): set valid[IDX]=1, write TAG, go to IDLE.
  - The next cycle's lookup then hits.
  - IF_valid_o=0 throughout REFILL.
  - Miss latency = refill cycles + 1.
  - IF_read_i dropping or IF_addr_i changing mid-refill has no effect; the refill completes.
- Flush:
  - In IDLE: all valid bits clear at the next edge, and IF_valid_o=0 in the flush cycle.
  - In REFILL: a pending flag is recorded. The outstanding word is still awaited (MEM_read_o stays 1 until MEM_valid_i), then the refill is abandoned without setting valid, all valids clear, and state goes to IDLE.
  - Flush and a hit in the same cycle: the hit is suppressed (IF_valid_o=0).
- Conflict: a miss to an occupied index overwrites the line (no write-back; read-only cache).
- Address wrap: base + counter wraps modulo 2^BITSIZE. Lines never straddle, since base is line-aligned.
- Elaboration check: a non-power-of-2 LINES or WORDS_PER_LINE is a fatal error.

Optional Feature:
- Macro ICACHE_STATS_EN.
- Defined:
  - hit_cnt_o increments on each cycle with IF_valid_o=1;
  - miss_cnt_o increments on each IDLE→REFILL transition;
  - both saturate at 0xFFFFFFFF, reset to 0, and are unaffected by flush.
- Undefined: hit_cnt_o and miss_cnt_o are tied to 0 and no counter flops exist.

Test Plan:
- Cold miss: after reset, read addr 0x0, with memory answering each read 2 cycles later.
  - MEM_addr_o steps through 0,1,2,3;
  - IF_valid_o=1 with data[0] the cycle after IDLE is re-entered;
  - reads at 1, 2, 3 then hit in the same cycle with no MEM_read_o;
  - with ICACHE_STATS_EN: hit=4, miss=1.
- Conflict: fill 0x0, then read 0x40 (same IDX, default params).
  - Refill at 0x40..0x43;
  - re-reading 0x0 misses again and refills 0x0..0x3.
- Flush in IDLE: after filling 0x10, pulse flush_i.
  - A read at 0x10 in the flush cycle gets IF_valid_o=0;
  - the next read at 0x10 misses and refills.
- Flush mid-refill: flush_i at word 1 of a refill at 0x20.
  - Word 1 is awaited;
  - no reads of 0x22/0x23;
  - the line is not valid;
  - a retry of 0x20 refills from 0x20.
- Reset mid-refill: deassert resetn_i during word 2 of a refill.
  - MEM_read_o=0 immediately;
  - after release, 0x0 misses (valid cleared).
- Back-pressure: MEM_valid_i delayed 10 cycles on word 0 while IF_read_i drops.
  - MEM_addr_o is stable and MEM_read_o=1 throughout;
  - the line becomes valid.
